// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the binary-to-BCD converter and the seven-segment display side.
package seven_seg_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } conv_state_t;

  localparam bcd_digit_t BCD_DIGIT_MAX = 4'd9;
  localparam bcd_digit_t BCD_BLANK     = 4'hF;

  // Largest value representable in 'digits' BCD digits (10^digits - 1).
  function automatic int unsigned bcd_max_value(input int digits);
    int unsigned v;
    v = 1;
    for (int i = 0; i < digits; i++) v = v * 10;
    return v - 1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// Single-digit double-dabble adjust: add 3 to any digit of 5 or more before the shift.
module bcd_add3
  import seven_seg_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Build option: define BCD_OVERFLOW_SAT_EN to saturate bcd to all nines on overflow.
module bin_to_bcd_seq
  import seven_seg_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int          SCR_W   = 4 * DIGITS;
  localparam int          CNT_W   = $clog2(BIN_W + 1);
  localparam int unsigned BCD_MAX = bcd_max_value(DIGITS);

  conv_state_t        state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [SCR_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [SCR_W-1:0]   bcd_q, bcd_d;
  logic               overflow_q, overflow_d;

  logic [SCR_W-1:0]   adj;
  logic [SCR_W-1:0]   shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .din  (scratch_q[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  // The top bit of the adjusted scratch falls off here: results wrap modulo 10^DIGITS.
  assign shifted = {adj[SCR_W-2:0], shift_q[BIN_W-1]};

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d    = bin;
          scratch_d  = '0;
          cnt_d      = '0;
          ovf_pend_d = (32'(bin) > BCD_MAX);
          busy_d     = 1'b1;
          state_d    = CONVERT;
        end
      end
      CONVERT: begin
        scratch_d = shifted;
        shift_d   = {shift_q[BIN_W-2:0], 1'b0};
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
`ifdef BCD_OVERFLOW_SAT_EN
          bcd_d = ovf_pend_q ? {DIGITS{BCD_DIGIT_MAX}} : shifted;
`else
          bcd_d = shifted;
`endif
          overflow_d = ovf_pend_q;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: vector table, handshake corner cases, random vs. model.
module tb_bin_to_bcd_seq;

  localparam int BIN_W  = 14;
  localparam int DIGITS = 4;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [BIN_W-1:0]  bin;
  logic              busy;
  logic              done;
  logic [15:0]       bcd;
  logic              overflow;

  int n_cmp;
  int n_fail;

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic [15:0]      bcd;
    logic             ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits of bin mod 10^4 by plain division.
  function automatic logic [16:0] ref_conv(input int b);
    int v;
    logic [15:0] r;
    v = b % 10000;
    r = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
`ifdef BCD_OVERFLOW_SAT_EN
    if (b > 9999) r = 16'h9999;
`endif
    return {(b > 9999) ? 1'b1 : 1'b0, r};
  endfunction

  // Issue one start, return edges from accept to done and busy cycles seen.
  task automatic convert(input logic [BIN_W-1:0] b, output int lat, output int busy_cnt);
    start = 1'b1;
    bin   = b;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout waiting for done: got 0, expected 1");
    end
  endtask

  vec_t vecs[6];
  int lat, bcnt, dcnt, j, first_done;
  logic [16:0] exp;

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset_n = 1'b0;
    start = 1'b0;
    bin = '0;

    vecs[0] = '{14'd1234,  16'h1234, 1'b0};
    vecs[1] = '{14'd0,     16'h0000, 1'b0};
    vecs[2] = '{14'd9999,  16'h9999, 1'b0};
`ifdef BCD_OVERFLOW_SAT_EN
    vecs[3] = '{14'd10000, 16'h9999, 1'b1};
    vecs[4] = '{14'd16383, 16'h9999, 1'b1};
`else
    vecs[3] = '{14'd10000, 16'h0000, 1'b1};
    vecs[4] = '{14'd16383, 16'h6383, 1'b1};
`endif
    vecs[5] = '{14'd81,    16'h0081, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_bcd", 32'(bcd), 0);
    check("reset_ovf", 32'(overflow), 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      convert(vecs[i].bin, lat, bcnt);
      check($sformatf("vec%0d_bcd", i), 32'(bcd), 32'(vecs[i].bcd));
      check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
      check($sformatf("vec%0d_latency", i), lat, BIN_W);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, BIN_W);
      check($sformatf("vec%0d_busy_at_done", i), 32'(busy), 0);
      @(negedge clk);
      check($sformatf("vec%0d_done_width", i), 32'(done), 0);
    end

    // Back-to-back: start held high through the first done.
    start = 1'b1;
    bin = 14'd0;
    @(negedge clk);
    bin = 14'd9999;
    dcnt = 0;
    first_done = -1;
    for (j = 0; j < 40; j++) begin
      if (done) begin
        dcnt++;
        if (dcnt == 1) begin
          first_done = j;
          check("b2b_first_bcd", 32'(bcd), 32'h0000);
        end else begin
          check("b2b_second_bcd", 32'(bcd), 32'h9999);
          check("b2b_second_at", j, 2 * BIN_W + 1);
          break;
        end
      end
      if (j == BIN_W + 1) start = 1'b0;
      @(negedge clk);
    end
    check("b2b_first_at", first_done, BIN_W);
    check("b2b_done_count", dcnt, 2);
    @(negedge clk);

    // start while busy is ignored; bin wiggles have no effect.
    start = 1'b1;
    bin = 14'd42;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0;
    for (j = 0; j < 40; j++) begin
      if (j == 3) begin start = 1'b1; bin = 14'd7777; end
      else begin start = 1'b0; bin = BIN_W'($urandom_range(0, 16383)); end
      if (j > 20) start = 1'b0;
      if (done) begin
        dcnt++;
        check("ignore_bcd", 32'(bcd), 32'h0042);
      end
      @(negedge clk);
    end
    check("ignore_done_count", dcnt, 1);
    check("ignore_idle_busy", 32'(busy), 0);

    // Reset mid-conversion.
    start = 1'b1;
    bin = 14'd5555;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_bcd", 32'(bcd), 0);
    check("abort_done", 32'(done), 0);
    check("abort_ovf", 32'(overflow), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    dcnt = 0;
    for (j = 0; j < 20; j++) begin
      if (done || busy) dcnt++;
      @(negedge clk);
    end
    check("abort_no_done", dcnt, 0);
    convert(14'd81, lat, bcnt);
    check("after_abort_bcd", 32'(bcd), 32'h0081);
    check("after_abort_latency", lat, BIN_W);
    @(negedge clk);

    // Random in-range operands against the reference model.
    for (int i = 0; i < 1000; i++) begin
      int b;
      logic ok;
      b = $urandom_range(0, 9999);
      exp = ref_conv(b);
      convert(BIN_W'(b), lat, bcnt);
      check($sformatf("rand%0d_bcd(bin=%0d)", i, b), 32'(bcd), 32'(exp[15:0]));
      check($sformatf("rand%0d_ovf", i), 32'(overflow), 32'(exp[16]));
      ok = 1'b1;
      for (int d = 0; d < DIGITS; d++) if (bcd[4*d +: 4] > 4'd9) ok = 1'b0;
      check($sformatf("rand%0d_digits_legal", i), 32'(ok), 1);
    end

    // A few random overflow operands as well.
    for (int i = 0; i < 20; i++) begin
      int b;
      b = $urandom_range(10000, 16383);
      exp = ref_conv(b);
      convert(BIN_W'(b), lat, bcnt);
      check($sformatf("rovf%0d_bcd(bin=%0d)", i, b), 32'(bcd), 32'(exp[15:0]));
      check($sformatf("rovf%0d_ovf", i), 32'(overflow), 32'(exp[16]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
